// File: rtl/wisc_mem_pkg.sv
// Shared types and geometry for the 16-bit word memory interface.
package wisc_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORD_BYTES      = 2;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = BLOCK_BYTES / WORD_BYTES;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches LIMIT.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  // Clear has priority; counting stops at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count < LIM)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill initiator: issues one read per word of the missing block,
// streams returned words into the data array, writes the tag on the last word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = wisc_mem_pkg::WORDS_PER_BLOCK,
  parameter int WORD_IDX_W      = wisc_mem_pkg::WORD_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  import wisc_mem_pkg::*;

  localparam int                    CNT_W    = WORD_IDX_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~ADDR_WIDTH'(WORDS_PER_BLOCK * WORD_BYTES - 1);

  fill_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [CNT_W-1:0]      w_issue_cnt;
  logic [CNT_W-1:0]      w_rcv_cnt;
  logic                  w_fill;
  logic                  w_start;
  logic                  w_mem_en;
  logic                  w_wr_data;
  logic                  w_last;

  assign w_fill    = (r_state == FILL);
  assign w_start   = (r_state == IDLE) && miss_detected;
  assign w_mem_en  = w_fill && (w_issue_cnt < CNT_FULL);
  assign w_wr_data = w_fill && memory_data_valid && (w_rcv_cnt < CNT_FULL);
  assign w_last    = w_wr_data && (w_rcv_cnt == CNT_LAST);

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_start),
    .i_en    (w_mem_en),
    .o_count (w_issue_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (WORDS_PER_BLOCK)
  ) u_rcv_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_start),
    .i_en    (w_wr_data),
    .o_count (w_rcv_cnt)
  );

  // Latch the block-aligned base on a miss; return to IDLE on the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_base_addr <= miss_address & BLK_MASK;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = w_fill;
  assign mem_en           = w_mem_en;
  assign mem_wr           = 1'b0;
  assign memory_address   = w_fill ?
    (r_base_addr + ADDR_WIDTH'(w_issue_cnt) * ADDR_WIDTH'(WORD_BYTES)) : '0;
  assign write_data_array = w_wr_data;
  assign fill_word        = w_rcv_cnt[WORD_IDX_W-1:0];
  assign fill_data        = memory_data;
  assign write_tag_array  = w_last;
  assign fill_done        = w_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a randomized latency memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy, mem_en, mem_wr;
  logic [15:0] memory_address;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array, fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .ADDR_WIDTH      (16),
    .WORDS_PER_BLOCK (8),
    .WORD_IDX_W      (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  typedef struct {
    bit          in_rst;
    bit          busy;
    bit          men;
    logic [15:0] addr;
    bit          wr;
    bit          tag;
    logic [15:0] data;
  } ctl_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
    bit          tag;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  ctl_t  exp_ctl[$];
  wr_t   exp_wr[$];
  resp_t resp_q[$];

  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_tags = 0;
  int last_tag_cyc = 0;

  // Reference model: a fill in progress, requests sent, words received.
  bit          m_busy = 1'b0;
  int          m_issued = 0;
  int          m_rcv = 0;
  logic [15:0] m_base = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle of stimulus; expectations for this cycle go to the scoreboard.
  task automatic run_cycle(input bit miss, input logic [15:0] addr, input bit do_rst);
    ctl_t        c;
    wr_t         w;
    bit          v;
    logic [15:0] d;
    @(posedge clk);
    #1;
    cyc++;
    if (!do_rst) rst = 1'b1;
    v = 1'b0;
    d = 16'($urandom);
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      v = 1'b1;
      d = resp_q[0].data;
      void'(resp_q.pop_front());
    end
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = v;
    memory_data       = d;

    c.in_rst = do_rst;
    c.busy   = m_busy && !do_rst;
    c.men    = c.busy && (m_issued < 8);
    c.addr   = m_base + 16'(2 * m_issued);
    c.wr     = c.busy && v && (m_rcv < 8);
    c.tag    = c.wr && (m_rcv == 7);
    c.data   = d;
    exp_ctl.push_back(c);
    if (c.wr) begin
      w.idx  = 3'(m_rcv);
      w.data = d;
      w.tag  = c.tag;
      exp_wr.push_back(w);
    end

    if (do_rst) begin
      m_busy = 1'b0; m_issued = 0; m_rcv = 0;
    end else if (m_busy) begin
      if (c.men) m_issued++;
      if (c.wr)  m_rcv++;
      if (c.tag) m_busy = 1'b0;
    end else if (miss) begin
      m_busy = 1'b1; m_base = addr & 16'hFFF0; m_issued = 0; m_rcv = 0;
    end

    if (do_rst) begin
      #1;
      rst = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || resp_q.size() > 0) && n < 300) begin
      run_cycle(1'b0, 16'h0, 1'b0);
      n++;
    end
    if (m_busy || resp_q.size() > 0) chk("drain_timeout", 32'(n), 32'd0);
    run_cycle(1'b0, 16'h0, 1'b0);
  endtask

  // Memory: every request returns one random word, in order, after lat cycles.
  always @(negedge clk) begin : mem_model
    resp_t r;
    int    due;
    if (mem_en === 1'b1) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due  = due;
      r.data = 16'($urandom);
      resp_q.push_back(r);
    end
  end

  // Monitor: compare every cycle, and pop the write scoreboard on each array write.
  always @(negedge clk) begin : monitor
    ctl_t c;
    wr_t  w;
    if (exp_ctl.size() > 0) begin
      c = exp_ctl.pop_front();
      chk("fsm_busy", fsm_busy, c.busy);
      chk("mem_en", mem_en, c.men);
      chk("mem_wr", mem_wr, 32'd0);
      if (c.men) chk("memory_address", memory_address, c.addr);
      if (c.in_rst) begin
        chk("addr_in_reset", memory_address, 32'd0);
        chk("fill_word_in_reset", fill_word, 32'd0);
      end
      chk("write_data_array", write_data_array, c.wr);
      chk("write_tag_array", write_tag_array, c.tag);
      chk("fill_done", fill_done, c.tag);
      chk("fill_data_pass", fill_data, c.data);
      if (write_tag_array === 1'b1) begin
        n_tags++;
        last_tag_cyc = cyc;
      end
      if (write_data_array === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", write_data_array, 32'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("fill_word", fill_word, w.idx);
          chk("fill_data_word", fill_data, w.data);
          chk("tag_with_word", write_tag_array, w.tag);
        end
      end
    end
  end

  initial begin
    int miss_cyc;
    int t0;
    int k;
    resp_t r;

    // Reset state
    run_cycle(1'b0, 16'h0, 1'b1);
    run_cycle(1'b0, 16'h0, 1'b1);
    run_cycle(1'b0, 16'h0, 1'b0);

    // Basic fill, latency 4: last word returns 12 cycles after the miss cycle
    lat_min = 4; lat_max = 4;
    t0 = n_tags;
    run_cycle(1'b1, 16'h1236, 1'b0);
    miss_cyc = cyc;
    drain();
    chk("basic_tag_count", 32'(n_tags - t0), 32'd1);
    chk("basic_completion_cycle", 32'(last_tag_cyc - miss_cyc), 32'd12);

    // Latency 1: responses overlap the issue phase
    lat_min = 1; lat_max = 1;
    t0 = n_tags;
    run_cycle(1'b1, 16'h1236, 1'b0);
    miss_cyc = cyc;
    drain();
    chk("lat1_tag_count", 32'(n_tags - t0), 32'd1);
    chk("lat1_completion_cycle", 32'(last_tag_cyc - miss_cyc), 32'd9);

    // Miss while busy is ignored
    lat_min = 2; lat_max = 2;
    t0 = n_tags;
    run_cycle(1'b1, 16'h1230, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 16'h4000, 1'b0);
    drain();
    chk("busy_miss_tag_count", 32'(n_tags - t0), 32'd1);

    // Reset after 3 words, late valids still in flight
    lat_min = 3; lat_max = 3;
    t0 = n_tags;
    run_cycle(1'b1, 16'h2222, 1'b0);
    k = 0;
    while (m_rcv < 3 && k < 50) begin
      run_cycle(1'b0, 16'h0, 1'b0);
      k++;
    end
    if (m_rcv < 3) chk("reset_wait_timeout", 32'(k), 32'd0);
    run_cycle(1'b0, 16'h0, 1'b1);
    drain();
    chk("reset_no_tag", 32'(n_tags - t0), 32'd0);

    // Back-to-back fills, second miss on the first IDLE cycle
    lat_min = 2; lat_max = 2;
    t0 = n_tags;
    run_cycle(1'b1, 16'hFFF2, 1'b0);
    k = 0;
    while (m_busy && k < 100) begin
      run_cycle(1'b0, 16'h0, 1'b0);
      k++;
    end
    run_cycle(1'b1, 16'h0010, 1'b0);
    drain();
    chk("b2b_tag_count", 32'(n_tags - t0), 32'd2);

    // Stray valid in IDLE
    t0 = n_tags;
    r.due  = cyc + 1;
    r.data = 16'hBEEF;
    resp_q.push_back(r);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0, 1'b0);
    chk("stray_no_tag", 32'(n_tags - t0), 32'd0);

    // Randomized traffic with variable latency and occasional resets
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(99, 0) < 30, 16'($urandom), $urandom_range(199, 0) == 0);
    end
    drain();

    @(negedge clk);
    #1;
    chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Initiator side of the 16-bit byte-addressed word memory interface. On a cache miss it requests every word of the missing block from data or instruction memory.
- Streams returned words into the cache data array, then writes the tag once the last word arrives.
- Sits between the L1 cache miss-detect logic and the multi-cycle memory. One instance serves I-cache and one serves D-cache.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2, at least 2.
- WORD_IDX_W, 3, log2(WORDS_PER_BLOCK).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- fsm_busy  out  1  high while a fill is in progress; the cache stalls the pipeline on it.
- mem_en  out  1  memory read request this cycle.
- mem_wr  out  1  memory write; tied 0 (read-only initiator).
- memory_address  out  ADDR_WIDTH  byte address of the current request; bit 0 is always 0.
- memory_data_valid  in  1  returned read data valid this cycle.
- memory_data  in  16  returned read data.
- write_data_array  out  1  write fill_data into the data array at fill_word.
- fill_word  out  WORD_IDX_W  word index within the block for the current data-array write.
- fill_data  out  16  memory_data passed through combinationally.
- write_tag_array  out  1  one-cycle pulse; write the tag and set valid for the block.
- fill_done  out  1  one-cycle pulse coincident with write_tag_array.

Behaviour:
- States: IDLE, FILL.
- Registers:
  - state.
  - base_addr: miss_address with its low WORD_IDX_W+1 bits cleared.
  - issue_cnt: WORD_IDX_W+1 bits, number of requests sent.
  - rcv_cnt: WORD_IDX_W+1 bits, number of words received.
- Reset (rst=0, asynchronous): state=IDLE, all counters 0, base_addr 0. All outputs 0, except fill_data, which follows memory_data.
- IDLE:
  - If miss_detected at a rising edge: latch base_addr, clear both counters, go to FILL.
  - memory_data_valid in IDLE is ignored; no array writes occur.
- FILL, requests:
  - mem_en = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base_addr + 2*issue_cnt.
  - issue_cnt increments on each cycle mem_en is high.
  - Requests therefore go out on the 8 consecutive cycles after the miss is latched, at base+0x0 through base+0xE.
- FILL, responses:
  - write_data_array = memory_data_valid && (rcv_cnt < WORDS_PER_BLOCK), with fill_word = rcv_cnt[WORD_IDX_W-1:0].
  - rcv_cnt increments on each such write.
  - Data is assumed to return in request order.
  - Response latency is arbitrary (≥1 cycle), including responses that overlap the issue phase.
- Completion:
  - On the cycle a valid arrives with rcv_cnt == WORDS_PER_BLOCK-1: the last word is written and write_tag_array=fill_done=1 in that same cycle.
  - Next state is IDLE.
- fsm_busy = (state == FILL), combinational. It drops the cycle after the completion cycle.
- miss_detected while in FILL is ignored. The cache holds the miss until fsm_busy falls, then re-presents it if it still misses.
- A valid arriving after completion, or when rcv_cnt has saturated, is ignored.
- Reset during FILL:
  - Immediate return to IDLE with counters cleared and no tag write.
  - Valids still in flight after reset release are ignored, because they arrive in IDLE.
- Back-to-back fills: a miss asserted on the first IDLE cycle after completion starts a new fill on the next edge. There is no dead cycle beyond the IDLE state itself.
- Address arithmetic is ADDR_WIDTH-bit and wraps modulo 2^ADDR_WIDTH. It cannot cross a block boundary because base_addr is block-aligned.

Decomposition:
- Package wisc_mem_pkg holds:
  - fill_state_t enum {IDLE, FILL};
  - constants WORD_BYTES=2, BLOCK_BYTES=16, WORDS_PER_BLOCK=8, WORD_IDX_W=3.
- One sub-module is natural: sat_counter (width parameter; enable, clear, saturate at a limit), instantiated twice, for issue_cnt and rcv_cnt.
- Address generation and the FSM stay in the top module.

Test Plan:
- Basic fill:
  - Stimulus: miss_address=0x1236, memory model with 4-cycle latency, word k returns 0xA000+k.
  - Response: mem_en high for 8 cycles at 0x1230..0x123E. write_data_array pulses with fill_word 0..7 and data 0xA000..0xA007. write_tag_array and fill_done pulse together with word 7. fsm_busy is high from the cycle after the miss through the completion cycle.
- Latency 1:
  - Stimulus: same miss, responses overlap the issue phase.
  - Response: completion 9 cycles after the miss edge, all 8 words written in order.
- Miss while busy:
  - Stimulus: miss_detected=1 with 0x4000 during a fill of 0x1230.
  - Response: no change to base_addr; only one tag write, for 0x1230.
- Reset mid-fill:
  - Stimulus: rst=0 after 3 words received; release while valids are still in flight.
  - Response: all outputs 0 asynchronously; no write_tag_array; late valids produce no write_data_array.
- Back-to-back:
  - Stimulus: miss 0xFFF2, then miss 0x0010 on the first IDLE cycle.
  - Response: addresses 0xFFF0..0xFFFE, then 0x0010..0x001E; two tag pulses.
- Stray valid:
  - Stimulus: memory_data_valid=1 in IDLE.
  - Response: no array writes; state stays IDLE.
